// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, MEM/WB payload,
// writeback-control bit positions and word-alignment helpers.
package mem_access_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned WB_W  = 2;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic [WB_W-1:0]  wb_ctl;
        logic [XLEN-1:0]  read_data;
        logic [XLEN-1:0]  alu_result;
        logic [REG_W-1:0] rd;
    } mem_wb_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

    // Clears both writeback enables so a faulted instruction retires without side effects.
    function automatic logic [WB_W-1:0] kill_wb(input logic [WB_W-1:0] wb);
        logic [WB_W-1:0] r;
        r              = wb;
        r[WB_REGWRITE] = 1'b0;
        r[WB_MEMTOREG] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// MEM/WB capture register: loads the retiring instruction, optionally with writeback
// suppressed; valid drops on any cycle nothing retires while the data fields hold.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        suppress,
    input  logic [1:0]  wb_ctl_in,
    input  logic [31:0] read_data_in,
    input  logic [31:0] alu_result_in,
    input  logic [4:0]  rd_in,
    output logic [1:0]  wb_ctl_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        valid_out
);

    mem_wb_t data_q, data_d;
    logic    valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (load) begin
            data_d.wb_ctl     = suppress ? kill_wb(wb_ctl_in) : wb_ctl_in;
            data_d.read_data  = read_data_in;
            data_d.alu_result = alu_result_in;
            data_d.rd         = rd_in;
            valid_d           = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign wb_ctl_out     = data_q.wb_ctl;
    assign read_data_out  = data_q.read_data;
    assign alu_result_out = data_q.alu_result;
    assign rd_out         = data_q.rd;
    assign valid_out      = valid_q;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-memory handshake with timeout, branch resolution,
// upstream stall and the MEM/WB register feeding writeback.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] add_result,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic [1:0]  wb_ctl_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        valid_out,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic              memop;
    logic              aligned;
    logic              wb_load;
    logic              wb_suppress;
    logic [31:0]       wb_rdata;

    assign memop         = valid_in & (memread | memwrite);
    assign aligned       = is_word_aligned(alu_result[1:0]);
    assign pcsrc         = valid_in & branch & zero;
    assign branch_target = add_result;

    // Next-state, handshake and MEM/WB load decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mis_d       = 1'b0;
        berr_d      = 1'b0;
        stall       = 1'b0;
        wb_load     = 1'b0;
        wb_suppress = 1'b0;
        wb_rdata    = 32'h0;

        unique case (state_q)
            ST_IDLE: begin
                if (memop && !aligned) begin
                    wb_load     = 1'b1;
                    wb_suppress = 1'b1;
                    mis_d       = 1'b1;
                end else if (memop) begin
                    stall   = 1'b1;
                    state_d = ST_ACCESS;
                    addr_d  = alu_result;
                    wdata_d = rdata2;
                    we_d    = memwrite;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end else if (valid_in) begin
                    wb_load = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Completion wins over a timeout that would expire on the same cycle.
                if (dmem_ready) begin
                    wb_load  = 1'b1;
                    wb_rdata = we_q ? 32'h0 : dmem_rdata;
                    req_d    = 1'b0;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_load     = 1'b1;
                    wb_suppress = 1'b1;
                    berr_d      = 1'b1;
                    req_d       = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

    mem_wb_reg u_mem_wb (
        .clk            (clk),
        .reset          (reset),
        .load           (wb_load),
        .suppress       (wb_suppress),
        .wb_ctl_in      (wb_ctl),
        .read_data_in   (wb_rdata),
        .alu_result_in  (alu_result),
        .rd_in          (rd_in),
        .wb_ctl_out     (wb_ctl_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out),
        .valid_out      (valid_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model of each instruction's per-cycle
// outputs, checked every cycle, plus literal expectations for the directed scenarios.
module tb_mem_access_stage;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, branch, memread, memwrite, zero;
    logic [1:0]  wb_ctl;
    logic [31:0] add_result, alu_result, rdata2;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pcsrc;
    logic [31:0] branch_target;
    logic [1:0]  wb_ctl_out;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  rd_out;
    logic        valid_out, misalign_err, bus_err;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .wb_ctl(wb_ctl), .branch(branch),
        .memread(memread), .memwrite(memwrite), .add_result(add_result), .zero(zero),
        .alu_result(alu_result), .rdata2(rdata2), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .wb_ctl_out(wb_ctl_out), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .rd_out(rd_out), .valid_out(valid_out),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Model: e_* is what the outputs must show this cycle, n_* what the next edge must capture.
    logic        e_stall, e_req, e_we, e_valid, e_mis, e_berr;
    logic [31:0] e_addr, e_wdata, e_rdata, e_alu;
    logic [1:0]  e_wb;
    logic [4:0]  e_rd;
    logic        n_req, n_we, n_valid, n_mis, n_berr;
    logic [31:0] n_addr, n_wdata, n_rdata, n_alu;
    logic [1:0]  n_wb;
    logic [4:0]  n_rd;

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp1(input string name, input logic act, input logic exp);
        cmp32(name, {31'h0, act}, {31'h0, exp});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp1("stall", stall, e_stall);
            cmp1("dmem_req", dmem_req, e_req);
            if (e_req) begin
                cmp1("dmem_we", dmem_we, e_we);
                cmp32("dmem_addr", dmem_addr, e_addr);
                cmp32("dmem_wdata", dmem_wdata, e_wdata);
            end
            cmp1("valid_out", valid_out, e_valid);
            cmp32("wb_ctl_out", 32'(wb_ctl_out), 32'(e_wb));
            cmp32("read_data_out", read_data_out, e_rdata);
            cmp32("alu_result_out", alu_result_out, e_alu);
            cmp32("rd_out", 32'(rd_out), 32'(e_rd));
            cmp1("misalign_err", misalign_err, e_mis);
            cmp1("bus_err", bus_err, e_berr);
            cmp1("pcsrc", pcsrc, valid_in & branch & zero);
            cmp32("branch_target", branch_target, add_result);
        end
    end

    task automatic model_clear();
        {e_stall, e_req, e_we, e_valid, e_mis, e_berr} = '0;
        {e_addr, e_wdata, e_rdata, e_alu, e_wb, e_rd} = '0;
        {n_req, n_we, n_valid, n_mis, n_berr} = '0;
        {n_addr, n_wdata, n_rdata, n_alu, n_wb, n_rd} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e_req = n_req; e_we = n_we; e_addr = n_addr; e_wdata = n_wdata;
        e_valid = n_valid; e_wb = n_wb; e_rdata = n_rdata; e_alu = n_alu; e_rd = n_rd;
        e_mis = n_mis; e_berr = n_berr;
        n_valid = 1'b0; n_mis = 1'b0; n_berr = 1'b0;
    endtask

    task automatic noise();
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
    endtask

    task automatic drive(input logic v, input logic mr, input logic mw, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd);
        valid_in = v; memread = mr; memwrite = mw; wb_ctl = wb;
        alu_result = alu; rdata2 = d2; rd_in = rd;
        branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
        add_result = $urandom;
    endtask

    task automatic do_bubble();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, 5'($urandom_range(0, 31)));
        noise();
        e_stall = 1'b0;
        step();
    endtask

    task automatic do_alu(input logic [1:0] wb, input logic [31:0] alu, input logic [4:0] rd);
        drive(1'b1, 1'b0, 1'b0, wb, alu, $urandom, rd);
        noise();
        e_stall = 1'b0;
        n_valid = 1'b1; n_wb = wb; n_rdata = 32'h0; n_alu = alu; n_rd = rd;
        step();
    endtask

    task automatic do_mis(input logic st, input logic [1:0] wb, input logic [31:0] alu,
                          input logic [4:0] rd);
        drive(1'b1, ~st, st, wb, alu, $urandom, rd);
        noise();
        e_stall = 1'b0;
        n_valid = 1'b1; n_wb = 2'b00; n_rdata = 32'h0; n_alu = alu; n_rd = rd; n_mis = 1'b1;
        step();
    endtask

    // lat = ACCESS cycle on which memory answers; lat > T never answers and times out.
    task automatic do_mem(input logic st, input logic [1:0] wb, input logic [31:0] alu,
                          input logic [31:0] d2, input logic [4:0] rd, input int lat,
                          input logic [31:0] rdata);
        int last;
        last = (lat <= int'(T)) ? lat : int'(T);
        drive(1'b1, ~st, st, wb, alu, d2, rd);
        noise();
        e_stall = 1'b1;
        n_req = 1'b1; n_we = st; n_addr = alu; n_wdata = d2;
        step();
        for (int k = 1; k <= last; k++) begin
            dmem_ready = (k == lat);
            dmem_rdata = (k == lat) ? rdata : $urandom;
            e_stall = (k < last);
            if (k == last) begin
                n_req = 1'b0; n_valid = 1'b1; n_alu = alu; n_rd = rd;
                if (lat <= int'(T)) begin
                    n_wb = wb; n_rdata = st ? 32'h0 : rdata;
                end else begin
                    n_wb = 2'b00; n_rdata = 32'h0; n_berr = 1'b1;
                end
            end
            step();
        end
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        cmp1("reset dmem_req", dmem_req, 1'b0);
        cmp1("reset valid_out", valid_out, 1'b0);
        cmp32("reset read_data_out", read_data_out, 32'h0);
        cmp32("reset dmem_addr", dmem_addr, 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        do_alu(2'b10, 32'h1234, 5'd5);
        cmp1("alu valid_out", valid_out, 1'b1);
        cmp32("alu alu_result_out", alu_result_out, 32'h1234);
        cmp32("alu rd_out", 32'(rd_out), 32'd5);

        do_mem(1'b0, 2'b11, 32'h100, 32'h5555, 5'd7, 1, 32'hDEADBEEF);
        cmp32("load read_data_out", read_data_out, 32'hDEADBEEF);
        cmp32("load dmem_addr", dmem_addr, 32'h100);
        cmp1("load dmem_we", dmem_we, 1'b0);
        cmp1("load req dropped", dmem_req, 1'b0);

        do_mem(1'b1, 2'b00, 32'h40, 32'hCAFE, 5'd0, 4, 32'h1111_2222);
        cmp32("store read_data_out", read_data_out, 32'h0);
        cmp1("store dmem_we", dmem_we, 1'b1);
        cmp32("store dmem_wdata", dmem_wdata, 32'hCAFE);

        do_mis(1'b0, 2'b11, 32'h102, 5'd3);
        cmp1("mis misalign_err", misalign_err, 1'b1);
        cmp32("mis wb_ctl_out", 32'(wb_ctl_out), 32'h0);
        cmp1("mis dmem_req", dmem_req, 1'b0);

        do_mem(1'b0, 2'b11, 32'h80, 32'h0, 5'd9, int'(T) + 1, 32'h0);
        cmp1("timeout bus_err", bus_err, 1'b1);
        cmp32("timeout wb_ctl_out", 32'(wb_ctl_out), 32'h0);
        cmp1("timeout dmem_req", dmem_req, 1'b0);
        do_bubble();
        cmp1("bus_err single pulse", bus_err, 1'b0);

        do_alu(2'b10, 32'h8, 5'd1);
        branch = 1'b1; zero = 1'b1; add_result = 32'h80;
        #1;
        cmp1("branch pcsrc", pcsrc, 1'b1);
        cmp32("branch target", branch_target, 32'h80);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            if (kind < 2) begin
                do_bubble();
            end else if (kind < 5) begin
                do_alu(2'($urandom_range(0, 3)), a, 5'($urandom_range(0, 31)));
            end else if (kind == 5) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                do_mis(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                       5'($urandom_range(0, 31)));
            end else begin
                a[1:0] = 2'b00;
                do_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
                       5'($urandom_range(0, 31)), $urandom_range(1, int'(T) + 1), $urandom);
            end
        end

        // Reset in the middle of an access.
        drive(1'b1, 1'b1, 1'b0, 2'b11, 32'h200, 32'h0, 5'd4);
        noise();
        e_stall = 1'b1;
        n_req = 1'b1; n_we = 1'b0; n_addr = 32'h200; n_wdata = 32'h0;
        step();
        dmem_ready = 1'b0;
        cmp1("pre-reset dmem_req", dmem_req, 1'b1);
        #2;
        chk_en = 1'b0;
        reset = 1'b1;
        #1;
        cmp1("async reset dmem_req", dmem_req, 1'b0);
        cmp1("async reset valid_out", valid_out, 1'b0);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk_en = 1'b1;
        do_alu(2'b01, 32'hABC0, 5'd2);
        do_bubble();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
